// File: rtl/gpu_pkg.sv
// Shared definitions for the data memory controller: width defaults,
// load/store encoding and the controller FSM state type.
package gpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  localparam logic MEM_LOAD  = 1'b1;
  localparam logic MEM_STORE = 1'b0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, deliberately no reset
// so contents survive a controller reset.
module mem_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the addressed word on the rising edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: accepts one LSU load/store at a time, models a
// fixed per-op access latency, and holds the response until the LSU takes it.
module data_mem_ctrl
  import gpu_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = 256,
  parameter int RD_LATENCY = 3,
  parameter int WR_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_lw_or_sw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_is_load,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Countdown start values: the accept edge counts as the first latency cycle
  localparam logic [3:0] RD_CNT = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WR_CNT = 4'(WR_LATENCY - 1);

  // DEPTH widened by one bit so the range check works even when DEPTH
  // equals 2**ADDR_W
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state;
  logic [3:0]        count;
  logic              op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              in_range;
  logic              access_fire;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  assign in_range    = ({1'b0, addr_q} < DEPTH_LIM);
  assign access_fire = (state == ACCESS) && (count == 4'd0);
  assign mem_we      = access_fire && (op_q == MEM_STORE) && in_range;

  // Reset forces IDLE asynchronously, so ready must also be masked directly
  assign req_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE);

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // Controller FSM: accept, count down the access latency, then hold the response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      op_q         <= MEM_STORE;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_is_load <= 1'b0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q    <= req_lw_or_sw;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            count   <= (req_lw_or_sw == MEM_LOAD) ? RD_CNT : WR_CNT;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == 4'd0) begin
            state        <= RESPOND;
            resp_valid   <= 1'b1;
            resp_is_load <= op_q;
            resp_err     <= !in_range;
            resp_rdata   <= ((op_q == MEM_LOAD) && in_range) ? mem_rdata : '0;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESPOND: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
